// File: rtl/button_seq_pkg.sv
// Shared types and helpers for the button sequencer and related stimulus blocks.
// State encoding, LFSR tap mask, default seed and the Galois LFSR step.
package button_seq_pkg;

    typedef enum logic [1:0] {
        S_GAP        = 2'd0,
        S_BOUNCE_IN  = 2'd1,
        S_HOLD       = 2'd2,
        S_BOUNCE_OUT = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Right-shifting Galois form of x^16+x^14+x^13+x^11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by the default seed
// so the register can never lock up.
module lfsr16
    import button_seq_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_r;

    // Advance every cycle, independent of any consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= INIT;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign q = lfsr_r;

endmodule

// File: rtl/button_sequencer.sv
// Timed button-press generator: gap, optional bounce in, clean hold, optional bounce out.
// Define BUTTON_SEQ_BOUNCE_EN to build the contact-bounce states.
module button_sequencer
    import button_seq_pkg::*;
#(
    parameter int          NBTN          = 5,
    parameter int          GAP_CYCLES    = 8,
    parameter int          PRESS_CYCLES  = 16,
    parameter int          BOUNCE_CYCLES = 4,
    parameter logic [15:0] SEED          = DEFAULT_SEED
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       mode,
    output logic [NBTN-1:0]            btn,
    output logic [sel_width(NBTN)-1:0] sel,
    output logic                       busy,
    output logic [15:0]                press_count
);

    localparam int SEL_W  = sel_width(NBTN);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int PH_MAX = (PRESS_CYCLES > BOUNCE_CYCLES) ? PRESS_CYCLES : BOUNCE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(PRESS_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NBTN - 1);
`ifdef BUTTON_SEQ_BOUNCE_EN
    localparam logic [PH_W-1:0]  BOUNCE_LAST = PH_W'(BOUNCE_CYCLES - 1);
`endif

    state_t           state_r, state_n;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_n;
    logic [PH_W-1:0]  phase_cnt_r, phase_cnt_n;
    logic [SEL_W-1:0] sel_r, sel_n, rr_sel_s, rand_sel_s;
    logic [7:0]       rand_idx_s;
    logic [NBTN-1:0]  btn_r, btn_n;
    logic             busy_r, busy_n;
    logic [15:0]      press_count_r, press_count_n;
    logic [15:0]      lfsr_s;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_s)
    );

    assign rand_idx_s = lfsr_s[7:0] % 8'(NBTN);
    assign rand_sel_s = rand_idx_s[SEL_W-1:0];
    assign rr_sel_s   = (sel_r == SEL_LAST) ? SEL_W'(0) : sel_r + SEL_W'(1);

    // Next state, counters and button selection; en only gates the gap counter.
    always_comb begin
        state_n       = state_r;
        gap_cnt_n     = gap_cnt_r;
        phase_cnt_n   = phase_cnt_r;
        sel_n         = sel_r;
        press_count_n = press_count_r;
        case (state_r)
            S_GAP: begin
                if (en) begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_n   = GAP_W'(0);
                        phase_cnt_n = PH_W'(0);
                        sel_n       = mode ? rand_sel_s : rr_sel_s;
`ifdef BUTTON_SEQ_BOUNCE_EN
                        state_n     = S_BOUNCE_IN;
`else
                        state_n     = S_HOLD;
`endif
                    end else begin
                        gap_cnt_n = gap_cnt_r + GAP_W'(1);
                    end
                end else begin
                    gap_cnt_n = gap_cnt_r;
                end
            end
`ifdef BUTTON_SEQ_BOUNCE_EN
            S_BOUNCE_IN: begin
                if (phase_cnt_r == BOUNCE_LAST) begin
                    phase_cnt_n = PH_W'(0);
                    state_n     = S_HOLD;
                end else begin
                    phase_cnt_n = phase_cnt_r + PH_W'(1);
                end
            end
`endif
            S_HOLD: begin
                if (phase_cnt_r == HOLD_LAST) begin
                    phase_cnt_n   = PH_W'(0);
`ifdef BUTTON_SEQ_BOUNCE_EN
                    state_n       = S_BOUNCE_OUT;
`else
                    state_n       = S_GAP;
                    press_count_n = press_count_r + 16'd1;
`endif
                end else begin
                    phase_cnt_n = phase_cnt_r + PH_W'(1);
                end
            end
`ifdef BUTTON_SEQ_BOUNCE_EN
            S_BOUNCE_OUT: begin
                if (phase_cnt_r == BOUNCE_LAST) begin
                    phase_cnt_n   = PH_W'(0);
                    state_n       = S_GAP;
                    press_count_n = press_count_r + 16'd1;
                end else begin
                    phase_cnt_n = phase_cnt_r + PH_W'(1);
                end
            end
`endif
            default: begin
                state_n     = S_GAP;
                phase_cnt_n = PH_W'(0);
            end
        endcase
    end

    // Output values are derived from the next state so they register in step with it.
    always_comb begin
        btn_n  = '0;
        busy_n = (state_n != S_GAP);
        case (state_n)
            S_HOLD: btn_n[sel_n] = 1'b1;
`ifdef BUTTON_SEQ_BOUNCE_EN
            S_BOUNCE_IN, S_BOUNCE_OUT: btn_n[sel_n] = lfsr_s[0];
`endif
            default: btn_n = '0;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_GAP;
            gap_cnt_r     <= GAP_W'(0);
            phase_cnt_r   <= PH_W'(0);
            sel_r         <= SEL_LAST;
            btn_r         <= '0;
            busy_r        <= 1'b0;
            press_count_r <= 16'd0;
        end else begin
            state_r       <= state_n;
            gap_cnt_r     <= gap_cnt_n;
            phase_cnt_r   <= phase_cnt_n;
            sel_r         <= sel_n;
            btn_r         <= btn_n;
            busy_r        <= busy_n;
            press_count_r <= press_count_n;
        end
    end

    assign btn         = btn_r;
    assign sel         = sel_r;
    assign busy        = busy_r;
    assign press_count = press_count_r;

endmodule
